puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
- Challenge-side controller for the dual-bank ring-oscillator PUF.
- On start, it issues NBITS oscillator-pair challenges to the two oscillator banks (sel_a, sel_b). For each pair it gates and clears the ripple counters, times a fixed measurement window, and freezes the oscillators.
- It then compares the two frozen counts and shifts one response bit into a register. The completed response is presented with a valid/ack handshake.
- Sits between the host challenge interface and the oscillator-bank/counter datapath; all logic is on clk.

Parameters:
- NBITS, 8, response bits per challenge (1..32).
- SEL_W, 4, oscillator select width per bank.
- CNT_W, 16, counter width of each bank.
- WIN_CYCLES, 1024, clk cycles oscillators run per measurement (>=1).
- SETTLE_CYCLES, 4, clk cycles for clear/freeze settling (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-high reset.
- start  in  1  begin a response generation; 1-cycle pulse.
- challenge  in  2*SEL_W  [SEL_W-1:0] = base_a, [2*SEL_W-1:0 upper half] = base_b; latched on accepted start.
- resp_ack  in  1  consumer accepts response.
- sel_a  out  SEL_W  oscillator select, bank A.
- sel_b  out  SEL_W  oscillator select, bank B.
- osc_en  out  1  oscillator enable, both banks.
- cnt_clear  out  1  counter clear, both banks; level, active-high.
- cnt_a  in  CNT_W  bank A count; sampled only in COMPARE.
- cnt_b  in  CNT_W  bank B count; sampled only in COMPARE.
- busy  out  1  high in any state except IDLE and DONE.
- response  out  NBITS  response word.
- resp_valid  out  1  response valid.
- tie_seen  out  1  sticky per run: some comparison had equal counts or sel_a==sel_b.
- ovf_seen  out  1  sticky per run: some compared count was all-ones.

Behaviour:
- Reset (async, rst_n=1) forces:
  - state IDLE; osc_en=0; cnt_clear=1.
  - sel_a=0, sel_b=0; response=0; resp_valid=0; busy=0.
  - tie_seen=0, ovf_seen=0; pair index 0; timers 0.
- Reset mid-run abandons the run with no partial result.
- Registered outputs; state changes take effect the cycle after the triggering edge.
- States:
  - IDLE: osc_en=0, cnt_clear=1. On start: latch challenge, idx<=0, clear tie_seen/ovf_seen/response, go CLEAR.
  - CLEAR: osc_en=0, cnt_clear=1. sel_a=(base_a+idx) mod 2^SEL_W, sel_b=(base_b+idx) mod 2^SEL_W. Lasts SETTLE_CYCLES, then MEASURE.
  - MEASURE: osc_en=1, cnt_clear=0. Lasts exactly WIN_CYCLES, then FREEZE.
  - FREEZE: osc_en=0, cnt_clear=0. Lasts SETTLE_CYCLES so the async counters stop and become stable, then COMPARE.
  - COMPARE: one cycle.
    - bit = (cnt_a > cnt_b), unsigned; tie gives 0 and sets tie_seen. sel_a==sel_b gives bit 0 and sets tie_seen.
    - Either count == 2^CNT_W-1 sets ovf_seen.
    - response[idx] <= bit.
    - If idx==NBITS-1 go DONE, else idx<=idx+1 and go CLEAR.
  - DONE: resp_valid=1, osc_en=0, cnt_clear=1, response held stable.
    - resp_ack: resp_valid<=0, go IDLE.
    - start (with or without resp_ack): start wins. resp_valid<=0, latch the new challenge, go CLEAR.
- start in CLEAR/MEASURE/FREEZE/COMPARE is ignored (no queueing).
- resp_ack outside DONE is ignored.
- Latency, start to resp_valid: 1 + NBITS*(2*SETTLE_CYCLES+WIN_CYCLES+1) cycles (single-measurement build).
- Select addition wraps modulo 2^SEL_W; no error on wrap.
- response bit i always corresponds to pair i (LSB first).

Optional Feature:
- Macro: PUF_MAJORITY_EN.
- Defined:
  - Each pair is measured 3 times (CLEAR→MEASURE→FREEZE→COMPARE repeated, same selects).
  - The bit is the majority of the 3 comparison results; tie_seen/ovf_seen accumulate over all 3.
  - Latency per bit is tripled.
- Undefined: single measurement per bit as above. No extra state or registers.

Test Plan:
1. Bench params NBITS=4, WIN_CYCLES=16, SETTLE_CYCLES=2. Bank model: count rate = sel+1 per 4 clk. start with base_a=5, base_b=2:
   - sel pairs (5,2),(6,3),(7,4),(8,5); response=4'b1111, tie_seen=0.
   - resp_valid exactly 1+4*21=85 cycles after start.
2. base_a=1, base_b=9: response=4'b0000. Hold resp_ack low 10 cycles: resp_valid and response stay stable. resp_ack pulse → resp_valid=0 and IDLE next cycle.
3. base_a=base_b=3: response=0, tie_seen=1.
4. base_a=14, base_b=0: sel_a sequence 14,15,0,1 (wrap checked). Force cnt_b=16'hFFFF on one pair → ovf_seen=1.
5. Assert rst_n during MEASURE of pair 2:
   - Immediately osc_en=0, cnt_clear=1, busy=0, response=0.
   - Next start runs a full 4-pair sequence from idx 0.
6. start during MEASURE is ignored (sel unchanged, latency unchanged). start and resp_ack together in DONE → new run begins with the new challenge. With PUF_MAJORITY_EN and bank A model noise flipping 1 of 3 compares → bit still 1.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : puf_challenge_sequencer
//  Description : Challenge-side controller for the dual-bank ring-oscillator
//                PUF. It walks NBITS oscillator pairs, times clear/measure/
//                freeze windows, and compares the frozen counts into a
//                response word that is offered with a valid/ack handshake.
//                Optional macro PUF_MAJORITY_EN: three measurements per pair,
//                with the response bit taken as the 2-of-3 majority.
//  Revision    : 1.0 - initial release
// ============================================================================
module puf_challenge_sequencer #(
   parameter int NBITS         = 8,
   parameter int SEL_W         = 4,
   parameter int CNT_W         = 16,
   parameter int WIN_CYCLES    = 1024,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2*SEL_W-1:0] challenge,
   input  logic               resp_ack,
   output logic [SEL_W-1:0]   sel_a,
   output logic [SEL_W-1:0]   sel_b,
   output logic               osc_en,
   output logic               cnt_clear,
   input  logic [CNT_W-1:0]   cnt_a,
   input  logic [CNT_W-1:0]   cnt_b,
   output logic               busy,
   output logic [NBITS-1:0]   response,
   output logic               resp_valid,
   output logic               tie_seen,
   output logic               ovf_seen
);

   localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int TMAX  = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W = $clog2(TMAX);

   localparam logic [TMR_W-1:0] c_win_last    = TMR_W'(WIN_CYCLES - 1);
   localparam logic [TMR_W-1:0] c_settle_last = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] c_idx_last    = IDX_W'(NBITS - 1);
   localparam logic [CNT_W-1:0] c_cnt_max     = '1;

   localparam logic [2:0] c_st_idle    = 3'd0;
   localparam logic [2:0] c_st_clear   = 3'd1;
   localparam logic [2:0] c_st_measure = 3'd2;
   localparam logic [2:0] c_st_freeze  = 3'd3;
   localparam logic [2:0] c_st_compare = 3'd4;
   localparam logic [2:0] c_st_done    = 3'd5;

   logic [2:0]       state_q,  state_d;
   logic [IDX_W-1:0] idx_q,    idx_d;
   logic [TMR_W-1:0] tmr_q,    tmr_d;
   logic [SEL_W-1:0] base_a_q, base_a_d;
   logic [SEL_W-1:0] base_b_q, base_b_d;
   logic [SEL_W-1:0] sel_a_q,  sel_a_d;
   logic [SEL_W-1:0] sel_b_q,  sel_b_d;
   logic [NBITS-1:0] resp_q,   resp_d;
   logic             tie_q,    tie_d;
   logic             ovf_q,    ovf_d;
   logic             osc_en_q, cnt_clear_q, busy_q, valid_q;
`ifdef PUF_MAJORITY_EN
   logic [1:0]       rep_q,    rep_d;
   logic [1:0]       votes_q,  votes_d;
`endif

   logic             w_sel_eq;
   logic             w_bit;
   logic             w_tie;
   logic             w_ovf;
   logic [IDX_W-1:0] w_idx_next;

   // Equal selects compare one oscillator against itself: force 0 and flag it.
   assign w_sel_eq   = (sel_a_q == sel_b_q);
   assign w_bit      = !w_sel_eq && (cnt_a > cnt_b);
   assign w_tie      = w_sel_eq || (cnt_a == cnt_b);
   assign w_ovf      = (cnt_a == c_cnt_max) || (cnt_b == c_cnt_max);
   assign w_idx_next = idx_q + IDX_W'(1);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tmr_d    = tmr_q;
      base_a_d = base_a_q;
      base_b_d = base_b_q;
      sel_a_d  = sel_a_q;
      sel_b_d  = sel_b_q;
      resp_d   = resp_q;
      tie_d    = tie_q;
      ovf_d    = ovf_q;
`ifdef PUF_MAJORITY_EN
      rep_d    = rep_q;
      votes_d  = votes_q;
`endif
      case (state_q)
         c_st_idle, c_st_done: begin
            if (start) begin
               base_a_d = challenge[SEL_W-1:0];
               base_b_d = challenge[2*SEL_W-1:SEL_W];
               sel_a_d  = challenge[SEL_W-1:0];
               sel_b_d  = challenge[2*SEL_W-1:SEL_W];
               idx_d    = '0;
               tmr_d    = '0;
               resp_d   = '0;
               tie_d    = 1'b0;
               ovf_d    = 1'b0;
`ifdef PUF_MAJORITY_EN
               rep_d    = 2'd0;
               votes_d  = 2'd0;
`endif
               state_d  = c_st_clear;
            end else if (resp_ack && (state_q == c_st_done)) begin
               state_d  = c_st_idle;
            end
         end
         c_st_clear: begin
            if (tmr_q == c_settle_last) begin
               tmr_d   = '0;
               state_d = c_st_measure;
            end else begin
               tmr_d   = tmr_q + TMR_W'(1);
            end
         end
         c_st_measure: begin
            if (tmr_q == c_win_last) begin
               tmr_d   = '0;
               state_d = c_st_freeze;
            end else begin
               tmr_d   = tmr_q + TMR_W'(1);
            end
         end
         c_st_freeze: begin
            if (tmr_q == c_settle_last) begin
               tmr_d   = '0;
               state_d = c_st_compare;
            end else begin
               tmr_d   = tmr_q + TMR_W'(1);
            end
         end
         c_st_compare: begin
            tie_d   = tie_q | w_tie;
            ovf_d   = ovf_q | w_ovf;
            state_d = c_st_clear;
`ifdef PUF_MAJORITY_EN
            if (rep_q != 2'd2) begin
               rep_d   = rep_q + 2'd1;
               votes_d = votes_q + {1'b0, w_bit};
            end else begin
               rep_d         = 2'd0;
               votes_d       = 2'd0;
               resp_d[idx_q] = (votes_q == 2'd2) || ((votes_q == 2'd1) && w_bit);
               if (idx_q == c_idx_last) begin
                  state_d = c_st_done;
               end else begin
                  idx_d   = w_idx_next;
                  sel_a_d = base_a_q + SEL_W'(w_idx_next);
                  sel_b_d = base_b_q + SEL_W'(w_idx_next);
               end
            end
`else
            resp_d[idx_q] = w_bit;
            if (idx_q == c_idx_last) begin
               state_d = c_st_done;
            end else begin
               idx_d   = w_idx_next;
               sel_a_d = base_a_q + SEL_W'(w_idx_next);
               sel_b_d = base_b_q + SEL_W'(w_idx_next);
            end
`endif
         end
         default: state_d = c_st_idle;
      endcase
   end

   // Outputs are registered from the next state so they switch with it.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q     <= c_st_idle;
         idx_q       <= '0;
         tmr_q       <= '0;
         base_a_q    <= '0;
         base_b_q    <= '0;
         sel_a_q     <= '0;
         sel_b_q     <= '0;
         resp_q      <= '0;
         tie_q       <= 1'b0;
         ovf_q       <= 1'b0;
         osc_en_q    <= 1'b0;
         cnt_clear_q <= 1'b1;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
`ifdef PUF_MAJORITY_EN
         rep_q       <= 2'd0;
         votes_q     <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         tmr_q       <= tmr_d;
         base_a_q    <= base_a_d;
         base_b_q    <= base_b_d;
         sel_a_q     <= sel_a_d;
         sel_b_q     <= sel_b_d;
         resp_q      <= resp_d;
         tie_q       <= tie_d;
         ovf_q       <= ovf_d;
         osc_en_q    <= (state_d == c_st_measure);
         cnt_clear_q <= (state_d == c_st_idle) || (state_d == c_st_clear) ||
                        (state_d == c_st_done);
         busy_q      <= (state_d != c_st_idle) && (state_d != c_st_done);
         valid_q     <= (state_d == c_st_done);
`ifdef PUF_MAJORITY_EN
         rep_q       <= rep_d;
         votes_q     <= votes_d;
`endif
      end
   end

   assign sel_a      = sel_a_q;
   assign sel_b      = sel_b_q;
   assign osc_en     = osc_en_q;
   assign cnt_clear  = cnt_clear_q;
   assign busy       = busy_q;
   assign response   = resp_q;
   assign resp_valid = valid_q;
   assign tie_seen   = tie_q;
   assign ovf_seen   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_challenge_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_puf_challenge_sequencer
//  Description : Self-checking bench: bank model plus a timeline model of the
//                sequencer checked every cycle, with literal spot checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_challenge_sequencer;
   localparam int NBITS  = 4;
   localparam int SEL_W  = 4;
   localparam int CNT_W  = 16;
   localparam int WIN    = 16;
   localparam int SETTLE = 2;
`ifdef PUF_MAJORITY_EN
   localparam int REPS = 3;
`else
   localparam int REPS = 1;
`endif
   localparam int PER    = 2*SETTLE + WIN + 1;
   localparam int PAIR_T = PER * REPS;
   localparam int TOTAL  = NBITS * PAIR_T;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [7:0]       challenge = 8'h00;
   logic             resp_ack = 1'b0;
   logic [3:0]       sel_a, sel_b, response;
   logic             osc_en, cnt_clear, busy, resp_valid, tie_seen, ovf_seen;
   logic [15:0]      cnt_a, cnt_b;

   int n_cmp = 0;
   int n_err = 0;

   puf_challenge_sequencer #(
      .NBITS(NBITS), .SEL_W(SEL_W), .CNT_W(CNT_W),
      .WIN_CYCLES(WIN), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
      .resp_ack(resp_ack), .sel_a(sel_a), .sel_b(sel_b), .osc_en(osc_en),
      .cnt_clear(cnt_clear), .cnt_a(cnt_a), .cnt_b(cnt_b), .busy(busy),
      .response(response), .resp_valid(resp_valid), .tie_seen(tie_seen),
      .ovf_seen(ovf_seen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Oscillator banks: count rate sel+1 per 4 clocks while enabled.
   int   acc_a = 0, acc_b = 0;
   logic f_ovf_b = 1'b0, f_noise_a = 1'b0;
   always @(posedge clk) begin
      if (cnt_clear) begin
         acc_a <= 0;
         acc_b <= 0;
      end else if (osc_en) begin
         acc_a <= acc_a + int'(sel_a) + 1;
         acc_b <= acc_b + int'(sel_b) + 1;
      end
   end
   assign cnt_a = f_noise_a ? 16'd0    : 16'(acc_a >> 2);
   assign cnt_b = f_ovf_b   ? 16'hFFFF : 16'(acc_b >> 2);

   // Reference model: mode 0 idle, 1 running (m_t cycles in), 2 done.
   int         m_mode = 0;
   int         m_t = 0;
   logic [3:0] m_ba = 4'd0, m_bb = 4'd0;
   int         m_ovf_pair = -1;
   bit         m_noise = 1'b0;
   int         ovf_pair_req = -1;
   bit         noise_req = 1'b0;
   logic [3:0] h_sa = 4'd0, h_sb = 4'd0, h_resp = 4'd0;
   bit         h_tie = 1'b0, h_ovf = 1'b0;

   function automatic logic [3:0] psel(input logic [3:0] base, input int p);
      return base + 4'(p);
   endfunction

   function automatic int cnt_of(input logic [3:0] s);
      return (int'(s) + 1) * WIN / 4;
   endfunction

   function automatic void rep_eval(input int p, input int r, output bit b, output bit t, output bit o);
      logic [3:0] sa, sb;
      int ca, cb;
      sa = psel(m_ba, p);
      sb = psel(m_bb, p);
      ca = (m_noise && p == 0 && r == 0) ? 0 : cnt_of(sa);
      cb = (p == m_ovf_pair) ? 65535 : cnt_of(sb);
      b  = (sa != sb) && (ca > cb);
      t  = (sa == sb) || (ca == cb);
      o  = (ca == 65535) || (cb == 65535);
   endfunction

   function automatic logic [3:0] resp_upto(input int np);
      logic [3:0] res;
      bit b, t, o;
      int votes;
      res = 4'd0;
      for (int p = 0; p < np; p++) begin
         votes = 0;
         for (int r = 0; r < REPS; r++) begin
            rep_eval(p, r, b, t, o);
            votes += int'(b);
         end
         res[p] = (2*votes > REPS);
      end
      return res;
   endfunction

   function automatic void flags_upto(input int nr, output bit tie, output bit ovf);
      bit b, t, o;
      tie = 1'b0;
      ovf = 1'b0;
      for (int k = 0; k < nr; k++) begin
         rep_eval(k / REPS, k % REPS, b, t, o);
         tie |= t;
         ovf |= o;
      end
   endfunction

   always @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         m_mode = 0; m_t = 0;
         h_sa = 4'd0; h_sb = 4'd0; h_resp = 4'd0; h_tie = 1'b0; h_ovf = 1'b0;
      end else if (m_mode == 1) begin
         if (m_t == TOTAL - 1) m_mode = 2;
         else m_t++;
      end else if (start) begin
         m_mode = 1; m_t = 0;
         m_ba = challenge[3:0]; m_bb = challenge[7:4];
         m_ovf_pair = ovf_pair_req; m_noise = noise_req;
      end else if (m_mode == 2 && resp_ack) begin
         m_mode = 0;
         h_sa = psel(m_ba, NBITS-1); h_sb = psel(m_bb, NBITS-1);
         h_resp = resp_upto(NBITS);
         flags_upto(NBITS*REPS, h_tie, h_ovf);
      end
   end

   // Bank overrides follow the model timeline, registered away from the edge.
   always @(negedge clk) begin
      f_ovf_b   <= (m_mode == 1) && (m_t / PAIR_T == m_ovf_pair);
      f_noise_a <= (m_mode == 1) && m_noise && (m_t / PER == 0);
   end

   always @(negedge clk) begin
      logic [3:0] e_sa, e_sb, e_resp;
      logic e_osc, e_clr, e_busy, e_val;
      bit e_tie, e_ovf;
      int ph;
      e_sa = 4'd0; e_sb = 4'd0; e_resp = 4'd0;
      e_osc = 1'b0; e_clr = 1'b1; e_busy = 1'b0; e_val = 1'b0;
      e_tie = 1'b0; e_ovf = 1'b0;
      if (!rst_n) begin
         if (m_mode == 0) begin
            e_sa = h_sa; e_sb = h_sb; e_resp = h_resp; e_tie = h_tie; e_ovf = h_ovf;
         end else if (m_mode == 2) begin
            e_sa = psel(m_ba, NBITS-1); e_sb = psel(m_bb, NBITS-1);
            e_resp = resp_upto(NBITS);
            flags_upto(NBITS*REPS, e_tie, e_ovf);
            e_val = 1'b1;
         end else begin
            ph     = m_t % PER;
            e_sa   = psel(m_ba, m_t / PAIR_T);
            e_sb   = psel(m_bb, m_t / PAIR_T);
            e_clr  = (ph < SETTLE);
            e_osc  = (ph >= SETTLE) && (ph < SETTLE + WIN);
            e_busy = 1'b1;
            e_resp = resp_upto(m_t / PAIR_T);
            flags_upto(m_t / PER, e_tie, e_ovf);
         end
      end
      chk("cycle{sa,sb,osc,clr,busy,vld,tie,ovf,resp}",
          {14'd0, sel_a, sel_b, osc_en, cnt_clear, busy, resp_valid, tie_seen, ovf_seen, response},
          {14'd0, e_sa, e_sb, e_osc, e_clr, e_busy, e_val, e_tie, e_ovf, e_resp});
   end

   logic [3:0] selq[$];
   bit cap_en = 1'b0;
   always @(negedge clk)
      if (cap_en && busy && (selq.size() == 0 || selq[$] != sel_a)) selq.push_back(sel_a);

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_start(input logic [3:0] ba, input logic [3:0] bb);
      challenge = {bb, ba};
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_valid(input bit noisy, input int lat0, output int lat);
      lat = lat0;
      while (!resp_valid && lat < 2000) begin
         if (noisy) begin
            start = ($urandom_range(0, 15) == 0);
            if (start) challenge = 8'($urandom);
            resp_ack = ($urandom_range(0, 15) == 0);
         end
         tick(1);
         lat++;
      end
      start = 1'b0;
      resp_ack = 1'b0;
      if (!resp_valid) begin
         n_cmp++;
         n_err++;
         $display("FAIL resp_valid_timeout: got 0 expected 1 at %0t", $time);
      end
   endtask

   task automatic ack_cycle();
      resp_ack = 1'b1;
      tick(1);
      resp_ack = 1'b0;
      chk("ack_valid_low", resp_valid, 0);
      chk("ack_idle_busy", busy, 0);
   endtask

   int lat;

   initial begin
      rst_n = 1'b1;
      tick(2);
      chk("rst_osc", osc_en, 0);
      chk("rst_clr", cnt_clear, 1);
      chk("rst_sel", {sel_a, sel_b}, 0);
      chk("rst_resp", {resp_valid, busy, tie_seen, ovf_seen, response}, 0);
      rst_n = 1'b0;
      tick(1);

      do_start(4'd5, 4'd2);
      wait_valid(1'b0, 1, lat);
      chk("t1_latency", lat, 1 + TOTAL);
      chk("t1_resp", response, 4'b1111);
      chk("t1_tie", tie_seen, 0);
      ack_cycle();

      do_start(4'd1, 4'd9);
      wait_valid(1'b0, 1, lat);
      tick(10);
      chk("t2_hold_valid", resp_valid, 1);
      chk("t2_resp", response, 4'b0000);
      ack_cycle();

      do_start(4'd3, 4'd3);
      wait_valid(1'b0, 1, lat);
      chk("t3_resp", response, 4'b0000);
      chk("t3_tie", tie_seen, 1);
      ack_cycle();

      ovf_pair_req = 0;
      selq.delete();
      cap_en = 1'b1;
      do_start(4'd14, 4'd0);
      wait_valid(1'b0, 1, lat);
      cap_en = 1'b0;
      ovf_pair_req = -1;
      chk("t4_resp", response, 4'b0010);
      chk("t4_ovf", ovf_seen, 1);
      chk("t4_nsel", selq.size(), 4);
      if (selq.size() == 4)
         chk("t4_selseq", {selq[0], selq[1], selq[2], selq[3]}, 16'hEF01);
      ack_cycle();

      do_start(4'd5, 4'd2);
      tick(2*PAIR_T + SETTLE + 4);
      chk("t5_in_measure", osc_en, 1);
      #2 rst_n = 1'b1;
      #1;
      chk("t5_rst_osc", osc_en, 0);
      chk("t5_rst_clr", cnt_clear, 1);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_resp", response, 0);
      @(posedge clk); #1 rst_n = 1'b0;
      tick(1);
      do_start(4'd5, 4'd2);
      wait_valid(1'b0, 1, lat);
      chk("t5_latency", lat, 1 + TOTAL);
      chk("t5_resp", response, 4'b1111);
      ack_cycle();

      do_start(4'd1, 4'd9);
      tick(SETTLE + 3);
      chk("t6_in_measure", osc_en, 1);
      challenge = 8'h77;
      start = 1'b1;
      resp_ack = 1'b1;
      tick(1);
      start = 1'b0;
      resp_ack = 1'b0;
      chk("t6_sel_kept", {sel_a, sel_b}, 8'h19);
      wait_valid(1'b0, SETTLE + 5, lat);
      chk("t6_latency", lat, 1 + TOTAL);
      chk("t6_resp", response, 4'b0000);
      noise_req = 1'b1;
      challenge = 8'h25;
      start = 1'b1;
      resp_ack = 1'b1;
      tick(1);
      start = 1'b0;
      resp_ack = 1'b0;
      chk("t6_restart_busy", busy, 1);
      chk("t6_restart_sel", {sel_a, sel_b}, 8'h52);
      wait_valid(1'b0, 1, lat);
      chk("t6b_latency", lat, 1 + TOTAL);
`ifdef PUF_MAJORITY_EN
      chk("t6b_resp_majority", response, 4'b1111);
`else
      chk("t6b_resp_noisy", response, 4'b1110);
`endif
      noise_req = 1'b0;
      ack_cycle();

      for (int it = 0; it < 8; it++) begin
         int op;
         op = int'($urandom_range(0, 4));
         ovf_pair_req = (op == 4) ? -1 : op;
         noise_req = bit'($urandom_range(0, 1));
         do_start(4'($urandom), 4'($urandom));
         wait_valid(1'b1, 1, lat);
         chk("rnd_latency", lat, 1 + TOTAL);
         tick(int'($urandom_range(0, 4)));
         if (it == 7 || $urandom_range(0, 1) == 1) ack_cycle();
      end

      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
